// File: rtl/host_instr_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : host_instr_driver
// Purpose  : Host-side driver for the accelerator instruction/result path.
//            Queues 64-bit host instructions in a command FIFO and issues
//            them one at a time, throttled by the accelerator buffer_full
//            flag. For result-read instructions it waits for the 32-bit
//            result and holds it for the host behind a valid/ready handshake.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            i_host_wr_en/_data        - host instruction push
//            o_host_full/_count        - FIFO status
//            o_acc_instr/_valid        - instruction to accelerator (strobe)
//            i_acc_buffer_full         - accelerator back-pressure
//            i_acc_result/_valid       - accelerator result
//            o_res_data/_valid, i_res_ready - result handshake to host
//            o_busy, o_overflow_err, o_timeout_err - status / sticky errors
// Revision : 1.0 - initial release
// ============================================================================
module host_instr_driver #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [3:0] RD_OPCODE   = 4'hF,
  parameter int         RES_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_host_wr_en,
  input  logic [63:0]                 i_host_wr_data,
  output logic                        o_host_full,
  output logic [$clog2(FIFO_DEPTH):0] o_host_count,
  output logic [63:0]                 o_acc_instr,
  output logic                        o_acc_instr_valid,
  input  logic                        i_acc_buffer_full,
  input  logic [31:0]                 i_acc_result,
  input  logic                        i_acc_result_valid,
  output logic [31:0]                 o_res_data,
  output logic                        o_res_valid,
  input  logic                        i_res_ready,
  output logic                        o_busy,
  output logic                        o_overflow_err,
  output logic                        o_timeout_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(RES_TIMEOUT + 1);
  localparam logic [TW-1:0] c_TO_LAST = TW'(RES_TIMEOUT - 1);
  localparam logic [CW-1:0] c_DEPTH   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RES = 2'd2,
    S_HOLD_RES = 2'd3
  } state_t;

  state_t        r_state;
  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_to_cnt;
  logic [63:0]   r_acc_instr;
  logic          r_acc_instr_valid;
  logic [31:0]   r_res_data;
  logic          r_res_valid;
  logic          r_overflow_err;
  logic          r_timeout_err;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == c_DEPTH);
  assign w_push = i_host_wr_en & ~w_full;
  // Pop only happens on the IDLE->ISSUE transition; buffer_full is ignored
  // in every other state.
  assign w_pop  = (r_state == S_IDLE) & (r_count != '0) & ~i_acc_buffer_full;

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_host_wr_data;
  end

  // FIFO control; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_host_wr_en && w_full) r_overflow_err <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue / result FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_acc_instr       <= '0;
      r_acc_instr_valid <= 1'b0;
      r_res_data        <= '0;
      r_res_valid       <= 1'b0;
      r_timeout_err     <= 1'b0;
      r_to_cnt          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_acc_instr       <= r_mem[r_rd_ptr];
            r_acc_instr_valid <= 1'b1;
            r_state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_acc_instr_valid <= 1'b0;
          r_to_cnt          <= '0;
          r_state <= (r_acc_instr[63:60] == RD_OPCODE) ? S_WAIT_RES : S_IDLE;
        end
        S_WAIT_RES: begin
          // A result arriving on the timeout cycle takes priority.
          if (i_acc_result_valid) begin
            r_res_data  <= i_acc_result;
            r_res_valid <= 1'b1;
            r_to_cnt    <= '0;
            r_state     <= S_HOLD_RES;
          end else if (r_to_cnt == c_TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_to_cnt      <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_HOLD_RES: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_host_full       = w_full;
  assign o_host_count      = r_count;
  assign o_acc_instr       = r_acc_instr;
  assign o_acc_instr_valid = r_acc_instr_valid;
  assign o_res_data        = r_res_data;
  assign o_res_valid       = r_res_valid;
  assign o_busy            = (r_state != S_IDLE) | (r_count != '0);
  assign o_overflow_err    = r_overflow_err;
  assign o_timeout_err     = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_host_instr_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_host_instr_driver
// Purpose  : Self-checking bench for host_instr_driver. Expected instructions
//            and results are queued when driven and compared when the DUT
//            issues / hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_instr_driver;

  localparam int DEPTH = 8;
  localparam int TO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [63:0] host_wr_data = '0;
  logic        host_full;
  logic [3:0]  host_count;
  logic [63:0] acc_instr;
  logic        acc_instr_valid;
  logic        acc_buffer_full = 1'b0;
  logic [31:0] acc_result = '0;
  logic        acc_result_valid = 1'b0;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        overflow_err;
  logic        timeout_err;

  host_instr_driver #(.FIFO_DEPTH(DEPTH), .RD_OPCODE(4'hF), .RES_TIMEOUT(TO)) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_host_wr_en       (host_wr_en),
    .i_host_wr_data     (host_wr_data),
    .o_host_full        (host_full),
    .o_host_count       (host_count),
    .o_acc_instr        (acc_instr),
    .o_acc_instr_valid  (acc_instr_valid),
    .i_acc_buffer_full  (acc_buffer_full),
    .i_acc_result       (acc_result),
    .i_acc_result_valid (acc_result_valid),
    .o_res_data         (res_data),
    .o_res_valid        (res_valid),
    .i_res_ready        (res_ready),
    .o_busy             (busy),
    .o_overflow_err     (overflow_err),
    .o_timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int n_issue = 0;
  int issue_cyc[$];
  logic [63:0] sb_instr[$];
  logic [31:0] sb_res[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_instr_valid) begin
        n_issue++;
        issue_cyc.push_back(cyc);
        if (sb_instr.size() == 0) chk("issue_unexpected", acc_instr, 64'hx);
        else chk("issue_data", acc_instr, sb_instr.pop_front());
      end
      if (res_valid && res_ready) begin
        if (sb_res.size() == 0) chk("result_unexpected", {32'd0, res_data}, 64'hx);
        else chk("result_data", {32'd0, res_data}, {32'd0, sb_res.pop_front()});
      end
    end
  end

  // All main-thread activity happens 1ns after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [63:0] d, input bit accept);
    host_wr_en   = 1'b1;
    host_wr_data = d;
    if (accept) sb_instr.push_back(d);
    step(1);
    host_wr_en = 1'b0;
  endtask

  task automatic wait_issue();
    int start = n_issue;
    for (int k = 0; k < 50 && n_issue == start; k++) step(1);
    if (n_issue == start) chk("issue_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_acc_instr"}, acc_instr, 64'd0);
    chk({tag, "_acc_valid"}, {63'd0, acc_instr_valid}, 64'd0);
    chk({tag, "_res_data"},  {32'd0, res_data}, 64'd0);
    chk({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
    chk({tag, "_count"},     {60'd0, host_count}, 64'd0);
    chk({tag, "_busy"},      {63'd0, busy}, 64'd0);
    chk({tag, "_ovf"},       {63'd0, overflow_err}, 64'd0);
    chk({tag, "_tout"},      {63'd0, timeout_err}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb_instr.delete();
    sb_res.delete();
    check_zero("reset");
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int b;
    int ic;
    int hold_issues;
    step(1);
    do_reset();

    // 1: three back-to-back non-read words.
    b = issue_cyc.size();
    for (int i = 1; i <= 3; i++) wr(64'(i), 1'b1);
    step(8);
    chk("t1_issues", 64'(issue_cyc.size() - b), 64'd3);
    if (issue_cyc.size() >= b + 3) begin
      chk("t1_gap0", 64'(issue_cyc[b+1] - issue_cyc[b]), 64'd2);
      chk("t1_gap1", 64'(issue_cyc[b+2] - issue_cyc[b+1]), 64'd2);
    end
    chk("t1_busy", {63'd0, busy}, 64'd0);
    chk("t1_sb_empty", 64'(sb_instr.size()), 64'd0);

    // 2: stall with buffer_full, overflow the FIFO, then drain.
    acc_buffer_full = 1'b1;
    b = n_issue;
    for (int i = 0; i <= DEPTH; i++) wr(64'h100 + 64'(i), i < DEPTH);
    step(3);
    chk("t2_no_issue", 64'(n_issue - b), 64'd0);
    chk("t2_full", {63'd0, host_full}, 64'd1);
    chk("t2_count", {60'd0, host_count}, 64'd8);
    chk("t2_ovf", {63'd0, overflow_err}, 64'd1);
    chk("t2_busy", {63'd0, busy}, 64'd1);
    acc_buffer_full = 1'b0;
    step(25);
    chk("t2_drained", 64'(n_issue - b), 64'd8);
    chk("t2_sb_empty", 64'(sb_instr.size()), 64'd0);

    // 3: read instruction, result held while host is not ready.
    wr(64'hF000_0000_0000_0005, 1'b1);
    wait_issue();
    ic = issue_cyc[$];
    wr(64'h7, 1'b1);
    while (cyc < ic + 4) step(1);
    acc_result = 32'hDEADBEEF;
    acc_result_valid = 1'b1;
    sb_res.push_back(32'hDEADBEEF);
    step(1);
    acc_result_valid = 1'b0;
    acc_result = '0;
    hold_issues = n_issue;
    for (int k = 0; k < 5; k++) begin
      chk("t3_res_valid", {63'd0, res_valid}, 64'd1);
      chk("t3_res_data", {32'd0, res_data}, 64'h0000_0000_DEAD_BEEF);
      step(1);
    end
    chk("t3_no_issue_hold", 64'(n_issue - hold_issues), 64'd0);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    chk("t3_res_dropped", {63'd0, res_valid}, 64'd0);
    step(5);
    chk("t3_sb_empty", 64'(sb_instr.size()), 64'd0);
    chk("t3_res_sb_empty", 64'(sb_res.size()), 64'd0);

    // 4: read with no result -> timeout, next word still issues.
    wr(64'hF000_0000_0000_0001, 1'b1);
    wr(64'h9, 1'b1);
    wait_issue();
    ic = issue_cyc[$];
    for (int k = 0; k < 200 && !timeout_err; k++) step(1);
    chk("t4_tout", {63'd0, timeout_err}, 64'd1);
    chk("t4_tout_cycle", 64'(cyc - ic), 64'(TO + 1));
    chk("t4_res_valid", {63'd0, res_valid}, 64'd0);
    step(4);
    chk("t4_next_issued", 64'(sb_instr.size()), 64'd0);
    chk("t4_tout_sticky", {63'd0, timeout_err}, 64'd1);

    // 5: result on the exact timeout cycle wins.
    do_reset();
    wr(64'hF000_0000_0000_0002, 1'b1);
    wait_issue();
    ic = issue_cyc[$];
    while (cyc < ic + TO) step(1);
    acc_result = 32'hCAFEF00D;
    acc_result_valid = 1'b1;
    sb_res.push_back(32'hCAFEF00D);
    step(1);
    acc_result_valid = 1'b0;
    chk("t5_res_valid", {63'd0, res_valid}, 64'd1);
    chk("t5_res_data", {32'd0, res_data}, 64'h0000_0000_CAFE_F00D);
    chk("t5_no_tout", {63'd0, timeout_err}, 64'd0);
    step(2);
    chk("t5_no_tout_later", {63'd0, timeout_err}, 64'd0);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    step(2);
    chk("t5_res_sb_empty", 64'(sb_res.size()), 64'd0);

    // 6: reset while holding a result with two words queued.
    wr(64'hF000_0000_0000_0003, 1'b1);
    wait_issue();
    wr(64'h21, 1'b1);
    wr(64'h22, 1'b1);
    acc_result = 32'h1234_5678;
    acc_result_valid = 1'b1;
    sb_res.push_back(32'h1234_5678);
    step(1);
    acc_result_valid = 1'b0;
    step(2);
    chk("t6_holding", {63'd0, res_valid}, 64'd1);
    chk("t6_queued", {60'd0, host_count}, 64'd2);
    b = n_issue;
    do_reset();
    step(10);
    chk("t6_no_issue", 64'(n_issue - b), 64'd0);
    chk("t6_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/host_instr_driver.md
Name: host_instr_driver

Overview:
Host-side counterpart of the accelerator's 64-bit instruction input and 32-bit result output. The block queues 64-bit instructions written by the host and issues them to the accelerator one at a time. Issue is throttled by the accelerator's buffer_full flag. For result-read instructions, the block waits for the 32-bit result, then holds it for the host behind a valid/ready handshake. It sits between the host/testbench bus and the accelerator top level, on the accelerator's internal clock.

Parameters:
FIFO_DEPTH, 8, command FIFO entries (power of two, >=2)
RD_OPCODE, 4'hF, value of instr[63:60] that marks a result-read instruction
RES_TIMEOUT, 64, cycles to wait for a result before flagging an error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
host_wr_en  input  1  push host_wr_data into command FIFO
host_wr_data  input  64  instruction word from host
host_full  output  1  FIFO holds FIFO_DEPTH entries (combinational from count)
host_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
acc_instr  output  64  instruction to accelerator_input
acc_instr_valid  output  1  one-cycle strobe: acc_instr is a new instruction
acc_buffer_full  input  1  accelerator buffer_full
acc_result  input  32  accelerator_output
acc_result_valid  input  1  acc_result holds a new result this cycle
res_data  output  32  captured result to host
res_valid  output  1  res_data valid
res_ready  input  1  host accepts res_data
busy  output  1  FSM not in IDLE, or FIFO non-empty
overflow_err  output  1  sticky: write attempted while host_full
timeout_err  output  1  sticky: result not received within RES_TIMEOUT

Behaviour:
- Reset (rst_n low, async): FIFO emptied (pointers and count 0), FSM=IDLE.
  - Outputs: acc_instr=0, acc_instr_valid=0, res_data=0, res_valid=0, overflow_err=0, timeout_err=0, timeout counter=0.
  - Reset asserted mid-operation discards queued instructions and any held result.
- FIFO:
  - Write is accepted when host_wr_en=1 and host_full=0.
  - Write while full: data dropped, overflow_err set and held until reset, count unchanged.
  - Write and pop in the same cycle: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_RES, HOLD_RES.
  - IDLE -> ISSUE when FIFO non-empty and acc_buffer_full=0, sampled at the clock edge.
    - On that edge: acc_instr <= FIFO head, FIFO pops.
    - Otherwise stay in IDLE; acc_buffer_full=1 stalls indefinitely with no error.
  - ISSUE: acc_instr_valid=1 for exactly this cycle.
    - acc_instr stays stable until the next issue.
    - Next state is WAIT_RES if acc_instr[63:60]==RD_OPCODE, else IDLE.
    - Throughput for non-read instructions is one issue per 2 cycles.
  - WAIT_RES: timeout counter increments each cycle.
    - On acc_result_valid=1: res_data <= acc_result, res_valid <= 1, counter cleared, go to HOLD_RES.
    - If the counter reaches RES_TIMEOUT-1 without a result: timeout_err <= 1, counter cleared, res_valid stays 0, go to IDLE.
    - If acc_result_valid and the timeout occur in the same cycle, the result wins and no error is raised.
  - HOLD_RES: res_valid=1 and res_data stable until res_ready=1.
    - On the res_ready edge: res_valid <= 0, go to IDLE.
    - No new instruction issues while in HOLD_RES; this preserves result ordering.
  - acc_result_valid outside WAIT_RES is ignored.
- acc_buffer_full is only sampled in IDLE. If it rises during ISSUE, the issued word is still considered delivered.
- busy = (state != IDLE) | (count != 0).

Test Plan:
- Reset, then write 3 non-read words 64'h1..64'h3 with acc_buffer_full=0 -> acc_instr_valid pulses 3 times, 2 cycles apart, carrying 1, 2, 3 in order; busy drops after the last issue.
- Hold acc_buffer_full=1, write FIFO_DEPTH+1 words -> no issue, host_full=1, count=8, overflow_err=1; release full -> exactly 8 words issue in order.
- Write 64'hF000_0000_0000_0005, drive acc_result=32'hDEADBEEF with acc_result_valid 4 cycles after the issue, res_ready=0 for 5 cycles -> res_valid held with DEADBEEF, no further issue until res_ready.
- Read instruction with no acc_result_valid -> timeout_err=1 exactly RES_TIMEOUT cycles after entering WAIT_RES, FSM back in IDLE, next queued word issues.
- acc_result_valid coincident with the timeout cycle -> result captured, timeout_err stays 0.
- Assert rst_n=0 while in HOLD_RES with 2 words queued -> all outputs 0 immediately, no issue after release.
